pipeline_debug_monitor: RTL and testbench

//   Synthesizable run-control and state-dump monitor for the five-stage core.
//   - Counts cycles, retired instructions, stall cycles and flushes.
//   - Detects program end: the same PC committed repeatedly (jal x0,0 self-loop).
//   - Also ends on a cycle limit or on an external request.
//   - On end, walks the register file through a read port and streams every

---
 rtl/pipeline_debug_monitor.sv | 164 ++++++++++++++++
 tb/tb_pipeline_debug_monitor.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_debug_monitor.sv
// Run-control and state-dump monitor for the five-stage core: performance counters,
// end-of-program detection and a valid/ready register file dump.
module pipeline_debug_monitor #(
  parameter int REG_WIDTH   = 64,
  parameter int PC_WIDTH    = 64,
  parameter int NUM_REGS    = 32,
  parameter int CNT_WIDTH   = 32,
  parameter int HALT_REPEAT = 4,
  parameter int MAX_CYCLES  = 0,
  parameter int IDX_W       = $clog2(NUM_REGS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 commit_valid,
  input  logic [PC_WIDTH-1:0]  commit_pc,
  input  logic                 stall,
  input  logic                 flush,
  input  logic                 dump_req,
  output logic [IDX_W-1:0]     rf_raddr,
  input  logic [REG_WIDTH-1:0] rf_rdata,
  output logic                 dump_valid,
  input  logic                 dump_ready,
  output logic [IDX_W-1:0]     dump_idx,
  output logic [REG_WIDTH-1:0] dump_data,
  output logic                 dump_last,
  output logic [1:0]           dump_cause,
  output logic [CNT_WIDTH-1:0] cycle_count,
  output logic [CNT_WIDTH-1:0] retire_count,
  output logic [CNT_WIDTH-1:0] stall_count,
  output logic [CNT_WIDTH-1:0] flush_count,
  output logic                 halted,
  output logic                 done
);

  localparam int NUM_CNT = 4;
  localparam int REP_W = $clog2(HALT_REPEAT + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGS - 1);
  localparam logic [REP_W-1:0] REP_HALT = REP_W'(HALT_REPEAT);

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_DUMP = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t               state_reg;
  logic [IDX_W-1:0]     idx_reg;
  logic [PC_WIDTH-1:0]  last_pc_reg;
  logic [REP_W-1:0]     rep_reg;
  logic [REP_W-1:0]     rep_next;
  logic [1:0]           cause_reg;
  logic                 halted_reg;
  logic                 done_reg;

  logic                 in_run;
  logic                 in_dump;
  logic                 halt_trig;
  logic                 limit_trig;

  // Counter order: cycle, retire, stall, flush.
  logic [NUM_CNT-1:0]                cnt_inc;
  logic [NUM_CNT-1:0][CNT_WIDTH-1:0] cnt_val;
  logic [NUM_CNT-1:0][CNT_WIDTH-1:0] cnt_next;

  assign in_run  = (state_reg == ST_RUN);
  assign in_dump = (state_reg == ST_DUMP);
  assign cnt_inc = {flush, stall, commit_valid, 1'b1};

  generate
    for (genvar gi = 0; gi < NUM_CNT; gi++) begin : g_cnt
      logic [CNT_WIDTH-1:0] count_reg;

      // Saturate at all-ones rather than wrapping.
      assign cnt_next[gi] = (cnt_inc[gi] && (count_reg != '1)) ? count_reg + 1'b1 : count_reg;
      assign cnt_val[gi]  = count_reg;

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          count_reg <= '0;
        end else if (in_run) begin
          count_reg <= cnt_next[gi];
        end
      end
    end
  endgenerate

  always_comb begin
    rep_next = rep_reg;
    if (commit_valid) begin
      if (commit_pc != last_pc_reg) begin
        rep_next = REP_W'(1);
      end else if (rep_reg != REP_HALT) begin
        rep_next = rep_reg + 1'b1;
      end
    end
  end

  assign halt_trig  = commit_valid && (rep_next == REP_HALT);
  assign limit_trig = (MAX_CYCLES != 0) && (cnt_next[0] == CNT_WIDTH'(MAX_CYCLES));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg   <= ST_RUN;
      idx_reg     <= '0;
      last_pc_reg <= '0;
      rep_reg     <= '0;
      cause_reg   <= 2'd0;
      halted_reg  <= 1'b0;
      done_reg    <= 1'b0;
    end else begin
      case (state_reg)
        ST_RUN: begin
          rep_reg <= rep_next;
          if (commit_valid) begin
            last_pc_reg <= commit_pc;
          end
          if (halt_trig || limit_trig || dump_req) begin
            state_reg  <= ST_DUMP;
            halted_reg <= 1'b1;
            idx_reg    <= '0;
            if (halt_trig) begin
              cause_reg <= 2'd1;
            end else if (limit_trig) begin
              cause_reg <= 2'd2;
            end else begin
              cause_reg <= 2'd3;
            end
          end
        end
        ST_DUMP: begin
          if (dump_ready) begin
            if (idx_reg == LAST_IDX) begin
              state_reg <= ST_DONE;
              done_reg  <= 1'b1;
            end else begin
              idx_reg <= idx_reg + 1'b1;
            end
          end
        end
        ST_DONE: begin
          state_reg <= ST_DONE;
        end
        default: begin
          state_reg <= ST_RUN;
        end
      endcase
    end
  end

  // The register file read is combinational, so the beat tracks idx directly.
  assign rf_raddr     = in_dump ? idx_reg : '0;
  assign dump_idx     = in_dump ? idx_reg : '0;
  assign dump_valid   = in_dump;
  assign dump_data    = rf_rdata;
  assign dump_last    = in_dump && (idx_reg == LAST_IDX);
  assign dump_cause   = cause_reg;
  assign halted       = halted_reg;
  assign done         = done_reg;
  assign cycle_count  = cnt_val[0];
  assign retire_count = cnt_val[1];
  assign stall_count  = cnt_val[2];
  assign flush_count  = cnt_val[3];

endmodule

// File: tb/tb_pipeline_debug_monitor.sv
// Scoreboard bench for pipeline_debug_monitor: a queue-based reference model of the
// main instance plus directed cycle-limit and saturation checks on two variants.
module tb_pipeline_debug_monitor;

  localparam int NR = 32;
  localparam int HR = 4;
  localparam int M_RUN = 0, M_DUMP = 1, M_DONE = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, rst_b, rst_c;
  logic        commit_valid;
  logic [63:0] commit_pc;
  logic        stall, flush, dump_req, dump_ready;
  logic [63:0] rf_mem [NR];

  logic [4:0]  raddr_a, idx_a, raddr_b, idx_b, raddr_c, idx_c;
  logic [63:0] rdata_a, data_a, rdata_b, data_b, rdata_c, data_c;
  logic        valid_a, last_a, halted_a, done_a;
  logic        valid_b, last_b, halted_b, done_b;
  logic        valid_c, last_c, halted_c, done_c;
  logic [1:0]  cause_a, cause_b, cause_c;
  logic [31:0] cyc_a, ret_a, stl_a, fl_a, cyc_b, ret_b, stl_b, fl_b;
  logic [3:0]  cyc_c, ret_c, stl_c, fl_c;

  assign rdata_a = rf_mem[raddr_a];
  assign rdata_b = rf_mem[raddr_b];
  assign rdata_c = rf_mem[raddr_c];

  pipeline_debug_monitor dut_a (
    .clk(clk), .rst(rst_a), .commit_valid(commit_valid), .commit_pc(commit_pc),
    .stall(stall), .flush(flush), .dump_req(dump_req), .rf_raddr(raddr_a), .rf_rdata(rdata_a),
    .dump_valid(valid_a), .dump_ready(dump_ready), .dump_idx(idx_a), .dump_data(data_a),
    .dump_last(last_a), .dump_cause(cause_a), .cycle_count(cyc_a), .retire_count(ret_a),
    .stall_count(stl_a), .flush_count(fl_a), .halted(halted_a), .done(done_a)
  );

  pipeline_debug_monitor #(.MAX_CYCLES(20)) dut_b (
    .clk(clk), .rst(rst_b), .commit_valid(commit_valid), .commit_pc(commit_pc),
    .stall(stall), .flush(flush), .dump_req(dump_req), .rf_raddr(raddr_b), .rf_rdata(rdata_b),
    .dump_valid(valid_b), .dump_ready(dump_ready), .dump_idx(idx_b), .dump_data(data_b),
    .dump_last(last_b), .dump_cause(cause_b), .cycle_count(cyc_b), .retire_count(ret_b),
    .stall_count(stl_b), .flush_count(fl_b), .halted(halted_b), .done(done_b)
  );

  pipeline_debug_monitor #(.CNT_WIDTH(4)) dut_c (
    .clk(clk), .rst(rst_c), .commit_valid(commit_valid), .commit_pc(commit_pc),
    .stall(stall), .flush(flush), .dump_req(dump_req), .rf_raddr(raddr_c), .rf_rdata(rdata_c),
    .dump_valid(valid_c), .dump_ready(dump_ready), .dump_idx(idx_c), .dump_data(data_c),
    .dump_last(last_c), .dump_cause(cause_c), .cycle_count(cyc_c), .retire_count(ret_c),
    .stall_count(stl_c), .flush_count(fl_c), .halted(halted_c), .done(done_c)
  );

  int checks = 0;
  int errors = 0;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endfunction

  // Reference model of dut_a: whole-program view (commit history, beat list).
  typedef struct {
    int          idx;
    logic [63:0] data;
    bit          last;
  } beat_t;

  beat_t           exp_q [$];
  logic [63:0]     pc_hist [$];
  longint unsigned m_cnt [4];
  int              m_state, m_cause, m_idx, beats_seen;
  bit              m_halted, m_done;

  function automatic longint unsigned sat_inc(input longint unsigned v);
    return (v < 64'hFFFF_FFFF) ? v + 1 : v;
  endfunction

  function automatic void model_reset();
    m_state = M_RUN;
    for (int i = 0; i < 4; i++) m_cnt[i] = 0;
    m_cause = 0;
    m_idx = 0;
    m_halted = 0;
    m_done = 0;
    pc_hist.delete();
    exp_q.delete();
  endfunction

  function automatic void model_step();
    bit is_halt;
    int cause;
    if (m_state == M_RUN) begin
      m_cnt[0] = sat_inc(m_cnt[0]);
      if (commit_valid) m_cnt[1] = sat_inc(m_cnt[1]);
      if (stall) m_cnt[2] = sat_inc(m_cnt[2]);
      if (flush) m_cnt[3] = sat_inc(m_cnt[3]);
      is_halt = 0;
      if (commit_valid) begin
        pc_hist.push_back(commit_pc);
        if (pc_hist.size() > HR) void'(pc_hist.pop_front());
        if (pc_hist.size() == HR) begin
          is_halt = 1;
          foreach (pc_hist[k]) if (pc_hist[k] != commit_pc) is_halt = 0;
        end
      end
      cause = is_halt ? 1 : (dump_req ? 3 : 0);
      if (cause != 0) begin
        m_state = M_DUMP;
        m_halted = 1;
        m_cause = cause;
        m_idx = 0;
        for (int i = 0; i < NR; i++) begin
          beat_t b;
          b.idx = i;
          b.data = rf_mem[i];
          b.last = (i == NR - 1);
          exp_q.push_back(b);
        end
      end
    end else if (m_state == M_DUMP) begin
      if (dump_ready) begin
        m_idx++;
        if (m_idx == NR) begin
          m_state = M_DONE;
          m_done = 1;
        end
      end
    end
  endfunction

  // Monitor: compares every presented beat with the head of the scoreboard queue.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_a && valid_a) begin
        if (exp_q.size() == 0) begin
          chk("beat_unexpected", 64'd1, 64'd0);
        end else begin
          chk("beat_idx", idx_a, exp_q[0].idx);
          chk("beat_data", data_a, exp_q[0].data);
          chk("beat_last", last_a, exp_q[0].last);
          if (dump_ready) begin
            void'(exp_q.pop_front());
            beats_seen++;
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    if (rst_a) model_step();
    #2;
  endtask

  task automatic set_in(input bit cv, input logic [63:0] pc, input bit st, input bit fl,
                        input bit rq, input bit rdy);
    commit_valid = cv;
    commit_pc = pc;
    stall = st;
    flush = fl;
    dump_req = rq;
    dump_ready = rdy;
  endtask

  task automatic check_a(input string tag);
    chk({tag, ":cycle_count"}, cyc_a, m_cnt[0]);
    chk({tag, ":retire_count"}, ret_a, m_cnt[1]);
    chk({tag, ":stall_count"}, stl_a, m_cnt[2]);
    chk({tag, ":flush_count"}, fl_a, m_cnt[3]);
    chk({tag, ":halted"}, halted_a, m_halted);
    chk({tag, ":done"}, done_a, m_done);
    chk({tag, ":cause"}, cause_a, m_cause);
    chk({tag, ":dump_valid"}, valid_a, m_state == M_DUMP);
    if (m_state != M_DUMP) begin
      chk({tag, ":idle_idx"}, idx_a, 0);
      chk({tag, ":idle_last"}, last_a, 0);
    end
  endtask

  task automatic reset_a();
    rst_a = 1'b0;
    model_reset();
    #1;
    chk("rst:cycle_count", cyc_a, 0);
    chk("rst:retire_count", ret_a, 0);
    chk("rst:stall_count", stl_a, 0);
    chk("rst:flush_count", fl_a, 0);
    chk("rst:dump_valid", valid_a, 0);
    chk("rst:halted", halted_a, 0);
    chk("rst:done", done_a, 0);
    chk("rst:cause", cause_a, 0);
    tick();
    tick();
    rst_a = 1'b1;
  endtask

  task automatic run_dump_to_done(input string tag, input int mode);
    for (int k = 0; k < 300 && m_state != M_DONE; k++) begin
      case (mode)
        0: set_in($urandom_range(0, 1), 64'h40, 0, 0, $urandom_range(0, 1), k[0]);
        default: set_in(0, 0, 0, 0, $urandom_range(0, 1), $urandom_range(0, 1));
      endcase
      tick();
      check_a(tag);
    end
    chk({tag, ":done_reached"}, done_a, 1);
    chk({tag, ":beats"}, beats_seen, NR);
    chk({tag, ":queue_empty"}, exp_q.size(), 0);
  endtask

  logic [63:0] halt_pcs [6];
  int n_stall;

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    halt_pcs = '{64'h0, 64'h4, 64'h8, 64'h8, 64'h8, 64'h8};
    for (int i = 0; i < NR; i++) rf_mem[i] = 64'(i) * 64'h11;
    set_in(0, 0, 0, 0, 0, 0);
    rst_a = 0; rst_b = 0; rst_c = 0;
    model_reset();
    beats_seen = 0;
    repeat (2) @(posedge clk);
    #2;
    rst_a = 1; rst_b = 1; rst_c = 1;

    // Random run, then reset in the middle of it.
    for (int k = 0; k < 15; k++) begin
      set_in($urandom_range(0, 1), {$urandom, $urandom}, $urandom_range(0, 1),
             $urandom_range(0, 1), 0, 0);
      tick();
      check_a("run");
    end
    reset_a();
    check_a("post_rst");

    // Halt on a self-loop, then dump under toggling backpressure.
    for (int k = 0; k < 6; k++) begin
      set_in(1, halt_pcs[k], $urandom_range(0, 1), $urandom_range(0, 1), 0, 0);
      tick();
      check_a("halt");
    end
    chk("halt:cause", cause_a, 1);
    chk("halt:retire_count", ret_a, 6);
    chk("halt:dump_valid", valid_a, 1);
    beats_seen = 0;
    run_dump_to_done("bp", 0);
    for (int k = 0; k < 4; k++) begin
      set_in(1, 64'h8, 1, 1, 1, 1);
      tick();
      check_a("done_idle");
    end

    // dump_req coincident with the halt trigger: halt wins.
    reset_a();
    for (int k = 0; k < 4; k++) begin
      set_in(1, 64'h100, 0, 0, k == 3, 0);
      tick();
      check_a("simul");
    end
    chk("simul:cause", cause_a, 1);
    beats_seen = 0;
    run_dump_to_done("simul", 1);

    // Request-only trigger, then reset while beat 5 is presented.
    reset_a();
    for (int k = 0; k < 5; k++) begin
      set_in(1, 64'h200 + 64'(k) * 4, 0, 0, 0, 0);
      tick();
    end
    set_in(0, 0, 0, 0, 1, 0);
    tick();
    check_a("req");
    chk("req:cause", cause_a, 3);
    for (int k = 0; k < 10 && m_idx < 5; k++) begin
      set_in(0, 0, 0, 0, 0, 1);
      tick();
      check_a("beat5");
    end
    chk("beat5:idx", idx_a, 5);
    rst_a = 0;
    model_reset();
    tick();
    chk("mid_dump_rst:dump_valid", valid_a, 0);
    chk("mid_dump_rst:halted", halted_a, 0);
    chk("mid_dump_rst:idx", idx_a, 0);
    rst_a = 1;

    // Randomised rounds against the model.
    for (int r = 0; r < 4; r++) begin
      reset_a();
      for (int i = 0; i < NR; i++) rf_mem[i] = {$urandom, $urandom};
      beats_seen = 0;
      for (int k = 0; k < 400 && m_state != M_DONE; k++) begin
        set_in($urandom_range(0, 9) < 6, 64'h1000 + 64'($urandom_range(0, 2)) * 4,
               $urandom_range(0, 1), $urandom_range(0, 3) == 0,
               $urandom_range(0, 63) == 0, $urandom_range(0, 1));
        tick();
        check_a("rand");
      end
      chk("rand:done_reached", done_a, 1);
      chk("rand:beats", beats_seen, NR);
    end

    // Cycle limit of 20 with no commits.
    set_in(0, 0, 0, 0, 0, 0);
    rst_b = 0;
    tick();
    rst_b = 1;
    n_stall = 0;
    for (int k = 1; k <= 26; k++) begin
      set_in(0, 0, $urandom_range(0, 1), 0, 0, 0);
      if (k <= 20) n_stall += int'(stall);
      tick();
      chk("limit:cycle_count", cyc_b, (k < 20) ? k : 20);
      chk("limit:halted", halted_b, k >= 20);
      chk("limit:cause", cause_b, (k >= 20) ? 2 : 0);
      if (k >= 20) chk("limit:stall_frozen", stl_b, n_stall);
    end

    // Saturation of 4-bit counters.
    rst_c = 0;
    tick();
    rst_c = 1;
    for (int k = 1; k <= 20; k++) begin
      set_in(0, 0, 1, 0, 0, 0);
      tick();
      chk("sat:stall_count", stl_c, (k < 15) ? k : 15);
      chk("sat:cycle_count", cyc_c, (k < 15) ? k : 15);
    end
    chk("sat:retire_count", ret_c, 0);
    chk("sat:halted", halted_c, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
